risc_alu: RTL and testbench

//  32-bit registered ALU/function unit of the RISC datapath, selected by 4-bit G_sel.

---
 rtl/risc_alu_if.sv | 17 +
 rtl/risc_alu.sv | 85 ++++++++
 tb/tb_risc_alu.sv | 83 ++++++++
 3 files changed

// File: rtl/risc_alu_if.sv
// ALU operand/result bundle: the datapath drives the operands and select,
// the ALU returns the registered result and status flags.
interface risc_alu_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       G_sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] alu_out;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;

  modport master (output G_sel, A, B, input alu_out, C, V, Z, N);
  modport slave  (input G_sel, A, B, output alu_out, C, V, Z, N);
endinterface

// File: rtl/risc_alu.sv
// Registered 32-bit ALU / function unit: arithmetic, logic and single-bit
// shifts selected by G_sel. Result and C/V/Z/N flags appear one cycle later.
module risc_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  risc_alu_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } alu_rsp_t;

  alu_rsp_t         rsp_d, rsp_q;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;

  // Adder B-side mux: G_sel[2:1] picks Y, G_sel[0] is the carry in.
  always_comb begin
    y   = '0;
    cin = bus.G_sel[0];
    unique case (bus.G_sel[2:1])
      2'b00: y = '0;
      2'b01: y = bus.B;
      2'b10: y = ~bus.B;
      2'b11: y = '1;
      default: y = '0;
    endcase
    // One bit wider than the datapath so the top bit is the carry out.
    sum = {1'b0, bus.A} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  end

  // Function select; Z and N always follow whatever result is chosen.
  always_comb begin
    rsp_d = '0;
    if (!bus.G_sel[3]) begin
      rsp_d.f = sum[WIDTH-1:0];
      rsp_d.c = sum[WIDTH];
      rsp_d.v = (bus.A[WIDTH-1] == y[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.A[WIDTH-1]);
    end else begin
      unique case (bus.G_sel[2:0])
        3'b000: rsp_d.f = bus.A & bus.B;
        3'b001: rsp_d.f = bus.A | bus.B;
        3'b010: rsp_d.f = bus.A ^ bus.B;
        3'b011: rsp_d.f = ~bus.A;
        3'b100: rsp_d.f = bus.B;
        3'b101: begin
          rsp_d.f = {1'b0, bus.B[WIDTH-1:1]};
          rsp_d.c = bus.B[0];
        end
        3'b110: begin
          rsp_d.f = {bus.B[WIDTH-2:0], 1'b0};
          rsp_d.c = bus.B[WIDTH-1];
        end
        3'b111: begin
          rsp_d.f = {bus.B[WIDTH-1], bus.B[WIDTH-1:1]};
          rsp_d.c = bus.B[0];
        end
        default: rsp_d.f = '0;
      endcase
    end
    rsp_d.z = (rsp_d.f == '0);
    rsp_d.n = rsp_d.f[WIDTH-1];
  end

  // Output register; reset clears everything, including Z.
  always_ff @(posedge clk) begin
    if (rst) rsp_q <= '0;
    else     rsp_q <= rsp_d;
  end

  assign bus.alu_out = rsp_q.f;
  assign bus.C       = rsp_q.c;
  assign bus.V       = rsp_q.v;
  assign bus.Z       = rsp_q.z;
  assign bus.N       = rsp_q.n;

endmodule

// File: tb/tb_risc_alu.sv
// Directed-vector bench for risc_alu; expected values are hand-computed.
module tb_risc_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  risc_alu_if #(.WIDTH(32)) bus ();

  risc_alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op away from the edge, let one rising edge register it, then
  // check the result and {C,V,Z,N}.
  task automatic op(input string tag, input logic r, input logic [3:0] g,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_f, input logic [3:0] exp_cvzn);
    @(negedge clk);
    rst       = r;
    bus.G_sel = g;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    chk({tag, ".out"}, bus.alu_out, exp_f);
    chk({tag, ".cvzn"}, {28'd0, bus.C, bus.V, bus.Z, bus.N}, {28'd0, exp_cvzn});
  endtask

  initial begin
    bus.G_sel = 4'b0010;
    bus.A     = 32'd3;
    bus.B     = 32'd4;

    // Reset held for two edges with live inputs, then first computed result.
    op("rst0", 1'b1, 4'b0010, 32'd3, 32'd4, 32'h0, 4'b0000);
    op("rst1", 1'b1, 4'b0010, 32'd3, 32'd4, 32'h0, 4'b0000);
    op("rel",  1'b0, 4'b0010, 32'd3, 32'd4, 32'd7, 4'b0000);

    // Arithmetic group
    op("passA",  1'b0, 4'b0000, 32'd5, 32'd7, 32'd5, 4'b0000);
    op("addc",   1'b0, 4'b0011, 32'd25, 32'd5, 32'd31, 4'b0000);
    op("addovf", 1'b0, 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0101);
    op("inc",    1'b0, 4'b0001, 32'hFFFFFFFF, 32'd0, 32'h0, 4'b1010);
    op("addnb",  1'b0, 4'b0100, 32'd5, 32'd7, 32'hFFFFFFFD, 4'b0001);
    op("sub0",   1'b0, 4'b0101, 32'd5, 32'd5, 32'h0, 4'b1010);
    op("subneg", 1'b0, 4'b0101, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0001);
    op("subovf", 1'b0, 4'b0101, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b1100);
    op("dec0",   1'b0, 4'b0110, 32'd0, 32'd9, 32'hFFFFFFFF, 4'b0001);
    op("passA7", 1'b0, 4'b0111, 32'd9, 32'd0, 32'd9, 4'b1000);

    // Transfer and shifts
    op("movB", 1'b0, 4'b1100, 32'd11, 32'd101, 32'd101, 4'b0000);
    op("shr",  1'b0, 4'b1101, 32'd0, 32'h80000001, 32'h40000000, 4'b1000);
    op("shl",  1'b0, 4'b1110, 32'd0, 32'h80000001, 32'h00000002, 4'b1000);
    op("sra",  1'b0, 4'b1111, 32'd0, 32'h80000001, 32'hC0000000, 4'b1001);

    // Back-to-back logic ops, then reset mid-stream, then recovery
    op("and", 1'b0, 4'b1000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000);
    op("or",  1'b0, 4'b1001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b0001);
    op("xor", 1'b0, 4'b1010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b0001);
    op("not", 1'b0, 4'b1011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0F0F0F0F, 4'b0000);
    op("rstmid", 1'b1, 4'b1001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 4'b0000);
    op("after",  1'b0, 4'b1001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
